data_mem_responder: RTL and testbench

Responder end of the core's data memory request/grant/rvalid interface. It answers the initiator's data_req/data_gnt/data_rvalid handshake and backs the interface with an internal word-organised RAM, a programmable grant delay and an out-of-range error response. It is used as the data memory in core-level simulation and on FPGA, and acts as the reference slave when verifying the load/store path.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/grant/rvalid data memory bus between a load/store initiator and a memory responder.
// The master drives request, address and write controls; the slave drives grant and response.
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    data_req_i;
    logic                    data_gnt_o;
    logic                    data_rvalid_o;
    logic [DATA_WIDTH-1:0]   data_addr_i;
    logic                    data_we_i;
    logic [DATA_WIDTH/8-1:0] data_be_i;
    logic [DATA_WIDTH-1:0]   data_wdata_i;
    logic [DATA_WIDTH-1:0]   data_rdata_o;
    logic                    data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: data memory responder backed by a word-organised RAM, with out-of-range error replies.
// Latency: grant after GNT_WAIT cycles of continuous request; response exactly one cycle after grant.
// Backpressure: the initiator holds its request until granted; at most one response is ever outstanding.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int GNT_WAIT   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_mem_responder_if.slave  bus
);
    localparam int         NUM_BYTES = DATA_WIDTH / 8;
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] GW        = 4'(GNT_WAIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rvalid_q, rvalid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    gnt;
    logic                    oor;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    unused_addr_lsb;

    assign idx             = bus.data_addr_i[ADDR_WIDTH+1:2];
    assign oor             = |(bus.data_addr_i >> (ADDR_WIDTH + 2));
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];

    // Grant is combinational so a held request is accepted in the cycle the count expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (GNT_WAIT == 0) begin
            gnt     = bus.data_req_i;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.data_req_i) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (!bus.data_req_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == GW) begin
                        gnt     = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Masking the grant during reset also suppresses the RAM write on that edge.
        if (rst_i) begin
            gnt = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = gnt;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        wr_en    = gnt & bus.data_we_i & ~oor;
        if (gnt) begin
            err_d   = oor;
            rdata_d = (!bus.data_we_i && !oor) ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // RAM contents survive reset; only byte lanes with an enable are updated.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (bus.data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata_q;
    assign bus.data_err_o    = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table and random traffic on a zero-wait instance,
// cycle table and random latency traffic on a two-cycle-wait instance.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_WIDTH(32)) if0 ();
    data_mem_responder_if #(.DATA_WIDTH(32)) if2 ();

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GNT_WAIT(0)) u0 (
        .clk_i(clk), .rst_i(rst), .bus(if0));
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .GNT_WAIT(2)) u2 (
        .clk_i(clk), .rst_i(rst), .bus(if2));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_err;
    } cyc_t;

    vec_t vt[$];
    cyc_t ct[$];

    logic [31:0] mdl [16];
    bit          pend, pend_err, rq, wr, oorf;
    logic [31:0] pend_rd, a, wd, m;
    logic [3:0]  be;
    int          wi, gap;

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] bev, input logic [31:0] wdata);
        if0.data_req_i   = req;
        if0.data_we_i    = we;
        if0.data_addr_i  = addr;
        if0.data_be_i    = bev;
        if0.data_wdata_i = wdata;
    endtask

    task automatic drive2(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        if2.data_req_i   = req;
        if2.data_we_i    = we;
        if2.data_addr_i  = addr;
        if2.data_be_i    = 4'hF;
        if2.data_wdata_i = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        vt.push_back(vec_t'{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back(vec_t'{1'b1, 32'h20,       4'hF, 32'h11223344, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b0, 32'h20,       4'hF, 32'h0,        32'h11BB33DD, 1'b0});
        vt.push_back(vec_t'{1'b1, 32'h0,        4'hF, 32'h0BADF00D, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b0, 32'h1000,     4'hF, 32'h0,        32'h0,        1'b1});
        vt.push_back(vec_t'{1'b1, 32'h1000,     4'hF, 32'h55555555, 32'h0,        1'b1});
        vt.push_back(vec_t'{1'b0, 32'h0,        4'hF, 32'h0,        32'h0BADF00D, 1'b0});
        vt.push_back(vec_t'{1'b1, 32'h30,       4'hF, 32'hCAFEF00D, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b1, 32'h30,       4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b0, 32'h33,       4'h0, 32'h0,        32'hCAFEF00D, 1'b0});
        vt.push_back(vec_t'{1'b0, 32'h12,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back(vec_t'{1'b0, 32'h80000010, 4'hF, 32'h0,        32'h0,        1'b1});
        vt.push_back(vec_t'{1'b1, 32'hFFC,      4'hF, 32'h76543210, 32'h0,        1'b0});
        vt.push_back(vec_t'{1'b0, 32'hFFC,      4'hF, 32'h0,        32'h76543210, 1'b0});

        //                req   we    addr     wdata         gnt   rv    rdata         err
        ct.push_back(cyc_t'{1'b1, 1'b1, 32'h40,  32'h01020304, 1'b0, 1'b0, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b1, 32'h40,  32'h01020304, 1'b0, 1'b0, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b1, 32'h40,  32'h01020304, 1'b1, 1'b0, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b0, 32'h0,        1'b0});
        ct.push_back(cyc_t'{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b1, 32'h40,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b1, 32'h40,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h1000, 32'h0,       1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h1000, 32'h0,       1'b0, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b1, 1'b0, 32'h1000, 32'h0,       1'b1, 1'b0, 32'h01020304, 1'b0});
        ct.push_back(cyc_t'{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,        1'b1});

        // Reset with a request held: nothing may be granted until release.
        rst = 1'b1;
        drive0(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("reset gnt", if0.data_gnt_o, 1'b0);
            chk("reset rvalid", if0.data_rvalid_o, 1'b0);
            chk("reset rdata", if0.data_rdata_o, 32'h0);
            chk("reset err", if0.data_err_o, 1'b0);
            chk("reset u2 rvalid", if2.data_rvalid_o, 1'b0);
        end
        rst = 1'b0;
        #1 chk("release gnt", if0.data_gnt_o, 1'b1);
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("release rvalid", if0.data_rvalid_o, 1'b1);
        chk("release rdata", if0.data_rdata_o, 32'h0);
        @(posedge clk); #1;

        // Back-to-back vector table on the zero-wait instance.
        for (int i = 0; i < vt.size(); i++) begin
            drive0(1'b1, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d gnt", i), if0.data_gnt_o, 1'b1);
            if (i > 0) begin
                chk($sformatf("vec%0d rvalid", i-1), if0.data_rvalid_o, 1'b1);
                chk($sformatf("vec%0d rdata", i-1), if0.data_rdata_o, vt[i-1].exp_rdata);
                chk($sformatf("vec%0d err", i-1), if0.data_err_o, vt[i-1].exp_err);
            end
            @(posedge clk); #1;
        end
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("vec last rvalid", if0.data_rvalid_o, 1'b1);
        chk("vec last rdata", if0.data_rdata_o, vt[vt.size()-1].exp_rdata);
        chk("idle gnt", if0.data_gnt_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold rvalid", if0.data_rvalid_o, 1'b0);
        chk("hold rdata", if0.data_rdata_o, vt[vt.size()-1].exp_rdata);
        chk("hold err", if0.data_err_o, 1'b0);
        @(posedge clk); #1;

        // Random traffic against a word-array model; first 16 accesses initialise the window.
        pend = 1'b0;
        for (int i = 0; i < 216; i++) begin
            wi = $urandom_range(0, 15);
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            rq = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 1) != 0);
            oorf = (i >= 16) && ($urandom_range(0, 7) == 0);
            if (i < 16) begin
                rq = 1'b1; wr = 1'b1; wi = i; be = 4'hF;
            end
            a = 32'h100 + 32'(wi * 4) + 32'($urandom_range(0, 3));
            if (oorf) a = a | (32'h1 << $urandom_range(12, 31));
            drive0(rq, wr, a, be, wd);
            @(negedge clk);
            chk($sformatf("rnd%0d gnt", i), if0.data_gnt_o, rq);
            chk($sformatf("rnd%0d rvalid", i), if0.data_rvalid_o, pend);
            if (pend) begin
                chk($sformatf("rnd%0d rdata", i), if0.data_rdata_o, pend_rd);
                chk($sformatf("rnd%0d err", i), if0.data_err_o, pend_err);
            end
            if (rq) begin
                pend_err = oorf;
                pend_rd  = 32'h0;
                if (!oorf && wr) begin
                    m = mdl[wi];
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m = (m & ~(32'hFF << (8*b))) | (wd & (32'hFF << (8*b)));
                    mdl[wi] = m;
                end else if (!oorf) begin
                    pend_rd = mdl[wi];
                end
            end
            pend = rq;
            @(posedge clk); #1;
        end
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rnd final rvalid", if0.data_rvalid_o, pend);
        if (pend) chk("rnd final rdata", if0.data_rdata_o, pend_rd);
        @(posedge clk); #1;

        // Reset lands in the grant cycle of a write to 0x30 while a read response is showing.
        drive0(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstseq read gnt", if0.data_gnt_o, 1'b1);
        @(posedge clk); #1;
        drive0(1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678);
        chk("rstseq pre rdata", if0.data_rdata_o, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        chk("rstseq async gnt", if0.data_gnt_o, 1'b0);
        chk("rstseq async rvalid", if0.data_rvalid_o, 1'b0);
        chk("rstseq async rdata", if0.data_rdata_o, 32'h0);
        chk("rstseq async err", if0.data_err_o, 1'b0);
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstseq no rvalid", if0.data_rvalid_o, 1'b0);
        @(posedge clk); #1;
        drive0(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstseq readback rvalid", if0.data_rvalid_o, 1'b1);
        chk("rstseq readback rdata", if0.data_rdata_o, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Two-cycle grant wait: per-cycle table incl. held pipelined requests and an abort.
        for (int i = 0; i < ct.size(); i++) begin
            drive2(ct[i].req, ct[i].we, ct[i].addr, ct[i].wdata);
            @(negedge clk);
            chk($sformatf("cyc%0d gnt", i), if2.data_gnt_o, ct[i].exp_gnt);
            chk($sformatf("cyc%0d rvalid", i), if2.data_rvalid_o, ct[i].exp_rv);
            chk($sformatf("cyc%0d rdata", i), if2.data_rdata_o, ct[i].exp_rd);
            chk($sformatf("cyc%0d err", i), if2.data_err_o, ct[i].exp_err);
            @(posedge clk); #1;
        end
        drive2(1'b0, 1'b0, 32'h0, 32'h0);

        // Random gaps between held reads: grant always lands on the third request cycle.
        for (int i = 0; i < 12; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                chk($sformatf("lat%0d idle gnt", i), if2.data_gnt_o, 1'b0);
                @(posedge clk); #1;
            end
            drive2(1'b1, 1'b0, 32'h40 + 32'($urandom_range(0, 3)), 32'h0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("lat%0d gnt c%0d", i, k), if2.data_gnt_o, (k == 2));
                @(posedge clk); #1;
            end
            drive2(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("lat%0d rvalid", i), if2.data_rvalid_o, 1'b1);
            chk($sformatf("lat%0d rdata", i), if2.data_rdata_o, 32'h01020304);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
